rf_write_arbiter: RTL and testbench
===================================

Name: rf_write_arbiter

Overview:
Shares the register file's single write port between two writeback requesters: A is the single-cycle ALU path, and B is the multi-cycle load/mul path.
- Fixed priority to A, with a starvation guard that forces a grant to B.
- Drives the register file's reg_write/write_reg/write_data from registered outputs.
- Keeps a per-register pending-write scoreboard (busy vector) that the issue stage uses for stalls.

Parameters:
XLEN, 32, data width of write data.
NREG, 32, number of architectural registers; address width is log2(NREG) = 5.
STARVE_MAX, 3, number of consecutive cycles B may be valid and refused before B is forced to win.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
a_valid  in  1  requester A holds a writeback.
a_ready  out  1  A's writeback is accepted this cycle.
a_rd  in  5  A destination register.
a_data  in  XLEN  A write data.
b_valid  in  1  requester B holds a writeback.
b_ready  out  1  B's writeback is accepted this cycle.
b_rd  in  5  B destination register.
b_data  in  XLEN  B write data.
busy_set  in  1  issue stage marks a destination register as pending.
busy_set_rd  in  5  register to mark pending.
rf_reg_write  out  1  write enable to the register file (registered).
rf_write_reg  out  5  write address to the register file (registered).
rf_write_data  out  XLEN  write data to the register file (registered).
busy  out  NREG  scoreboard; bit r = 1 means a write to register r is pending.

Behaviour:
- Reset (asynchronous, immediate):
  - rf_reg_write=0, rf_write_reg=0, rf_write_data=0, busy=0, starve counter=0.
  - Writes that were accepted but not yet driven to the register file are discarded.
- Handshake:
  - A transfer occurs when valid && ready at a rising edge.
  - ready is combinational from valid and arbiter state, and never depends on the other requester's ready.
  - A requester holds valid, rd and data stable until it is accepted.
- Arbitration:
  - If starve_cnt == STARVE_MAX and b_valid: b_ready=1, a_ready=0.
  - Else if a_valid: a_ready=1.
  - Else if b_valid: b_ready=1.
  - At most one ready is high per cycle; there is no grant when neither requester is valid.
- Starve counter (2-bit minimum width, saturating at STARVE_MAX):
  - Increments each cycle b_valid && !b_ready.
  - Clears on a B transfer, and clears on any cycle with !b_valid.
- Latency:
  - A grant in cycle N produces rf_reg_write=1 in cycle N+1, with the granted rd and data.
  - The register file commits at the end of cycle N+1.
  - Back-to-back grants give one write per cycle, so throughput is 1 write per cycle.
- Register x0:
  - A transfer with rd==0 is accepted normally, but rf_reg_write stays 0 in cycle N+1.
  - busy[0] is constant 0; busy_set with rd 0 is ignored.
- Scoreboard:
  - busy[r] sets at the edge where busy_set && busy_set_rd==r (r != 0).
  - busy[r] clears at the edge where rf_reg_write && rf_write_reg==r, i.e. the same edge at which the register file commits.
  - Same edge sets and clears the same r: the set wins, because a newer producer is pending.
- Same destination from both requesters: A wins (absent forced B), and B's write lands later.
  - The last write wins in the register file; ordering is the requesters' responsibility.

Decomposition:
- Shared package rf_pkg:
  - XLEN, NREG and REG_ADDR_W=5 constants.
  - REG_ZERO=5'd0.
  - Requester-id enum {REQ_A, REQ_B}.
  - Writeback struct {rd, data}.
- One sub-module, rf_scoreboard: the busy-vector set/clear logic with set-wins priority and the x0 mask.
  - It is instantiated once, inside rf_write_arbiter.

Test Plan:
1. Reset mid-stream: assert rst while b_valid is held.
   -> All outputs are 0 immediately; b_ready=0 during reset.
   -> After release, the first grant writes on the following cycle.
2. A only: a_rd=5, a_data=0xDEADBEEF held valid 1 cycle.
   -> a_ready=1 in cycle N; in N+1 rf_reg_write=1, rf_write_reg=5, rf_write_data=0xDEADBEEF.
3. Starvation: a_valid=1 continuously, b_valid=1 with b_rd=7.
   -> b_ready=0 for exactly 3 cycles, b_ready=1 in the 4th cycle.
   -> rf_write_reg=7 one cycle later; the counter is back at 0.
4. x0 write: a_rd=0, a_data=0x1.
   -> a_ready=1, rf_reg_write stays 0, busy remains 0.
   -> busy_set with rd=0 leaves busy[0]=0.
5. Scoreboard: busy_set with rd=9 sets busy[9] next cycle.
   -> A B writeback to 9 clears busy[9] at the edge ending its rf_reg_write cycle.
   -> Repeat with busy_set rd=9 coincident with that clear edge: busy[9] stays 1.
6. Back-to-back: A and B are both valid with rd 3 and 4 for 2 cycles.
   -> Writes to 3 then 4 in consecutive cycles, with no idle cycle between them.

Source files
------------

// File: rtl/rf_write_arbiter_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
package rf_pkg;

  localparam int XLEN       = 32;
  localparam int NREG       = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_t;

  function automatic logic is_reg_zero(input logic [REG_ADDR_W-1:0] rd);
    return rd == REG_ZERO;
  endfunction

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Writeback request bundle for the two requesters sharing the write port.
// Handshake: a transfer happens on a rising edge where valid && ready; the
// requester holds valid, rd and data stable until that edge.
interface rf_write_arbiter_if #(
  parameter int XLEN       = rf_pkg::XLEN,
  parameter int REG_ADDR_W = rf_pkg::REG_ADDR_W
);
  logic                  a_valid;
  logic                  a_ready;
  logic [REG_ADDR_W-1:0] a_rd;
  logic [XLEN-1:0]       a_data;
  logic                  b_valid;
  logic                  b_ready;
  logic [REG_ADDR_W-1:0] b_rd;
  logic [XLEN-1:0]       b_data;

  modport master (
    output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    input  a_ready, b_ready
  );

  modport slave (
    input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    output a_ready, b_ready
  );
endinterface

// File: rtl/rf_write_arbiter_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set wins over clear,
// register x0 never busy.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NREG = rf_pkg::NREG
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_set,
  input  logic [REG_ADDR_W-1:0] i_set_rd,
  input  logic                  i_clr,
  input  logic [REG_ADDR_W-1:0] i_clr_rd,
  output logic [NREG-1:0]       o_busy
);

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_next;

  always_comb begin
    w_busy_next = r_busy;
    for (int r = 1; r < NREG; r++) begin
      // A newer producer issued on the commit edge keeps the bit pending.
      if (i_set && (i_set_rd == REG_ADDR_W'(r))) begin
        w_busy_next[r] = 1'b1;
      end else if (i_clr && (i_clr_rd == REG_ADDR_W'(r))) begin
        w_busy_next[r] = 1'b0;
      end
    end
    w_busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  assign o_busy = r_busy;

endmodule

// File: rtl/rf_write_arbiter.sv
// Fixed-priority (A over B) arbiter for the register file's single write
// port, with a starvation guard for B and registered register-file outputs.
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int XLEN       = rf_pkg::XLEN,
  parameter int NREG       = rf_pkg::NREG,
  parameter int STARVE_MAX = 3,
  localparam int CNT_W     = (STARVE_MAX < 4) ? 2 : $clog2(STARVE_MAX + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  rf_write_arbiter_if.slave     wb,
  input  logic                  busy_set,
  input  logic [REG_ADDR_W-1:0] busy_set_rd,
  output logic                  rf_reg_write,
  output logic [REG_ADDR_W-1:0] rf_write_reg,
  output logic [XLEN-1:0]       rf_write_data,
  output logic [NREG-1:0]       busy,
  output logic [CNT_W-1:0]      o_dbg_starve_cnt
);

  logic [CNT_W-1:0]      r_starve_cnt;
  logic [CNT_W-1:0]      w_starve_next;
  logic                  w_force_b;
  logic                  w_a_ready;
  logic                  w_b_ready;
  logic                  w_grant;
  req_id_e               w_grant_id;
  logic [REG_ADDR_W-1:0] w_sel_rd;
  logic [XLEN-1:0]       w_sel_data;

  logic                  r_reg_write;
  logic [REG_ADDR_W-1:0] r_write_reg;
  logic [XLEN-1:0]       r_write_data;

  always_comb begin
    w_force_b  = wb.b_valid && (r_starve_cnt == CNT_W'(STARVE_MAX));
    // Readies are held low while reset is asserted so nothing is accepted.
    w_a_ready  = !rst && wb.a_valid && !w_force_b;
    w_b_ready  = !rst && wb.b_valid && (w_force_b || !wb.a_valid);
    w_grant    = w_a_ready || w_b_ready;
    w_grant_id = w_b_ready ? REQ_B : REQ_A;
    w_sel_rd   = (w_grant_id == REQ_B) ? wb.b_rd   : wb.a_rd;
    w_sel_data = (w_grant_id == REQ_B) ? wb.b_data : wb.a_data;
  end

  always_comb begin
    w_starve_next = r_starve_cnt;
    if (!wb.b_valid || w_b_ready) begin
      w_starve_next = '0;
    end else if (r_starve_cnt != CNT_W'(STARVE_MAX)) begin
      w_starve_next = r_starve_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve_cnt <= '0;
      r_reg_write  <= 1'b0;
      r_write_reg  <= '0;
      r_write_data <= '0;
    end else begin
      r_starve_cnt <= w_starve_next;
      r_reg_write  <= w_grant && !is_reg_zero(w_sel_rd);
      if (w_grant) begin
        r_write_reg  <= w_sel_rd;
        r_write_data <= w_sel_data;
      end
    end
  end

  rf_scoreboard #(
    .NREG (NREG)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .i_set    (busy_set),
    .i_set_rd (busy_set_rd),
    .i_clr    (r_reg_write),
    .i_clr_rd (r_write_reg),
    .o_busy   (busy)
  );

  assign wb.a_ready       = w_a_ready;
  assign wb.b_ready       = w_b_ready;
  assign rf_reg_write     = r_reg_write;
  assign rf_write_reg     = r_write_reg;
  assign rf_write_data    = r_write_data;
  assign o_dbg_starve_cnt = r_starve_cnt;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter with hand-computed expected values.
module tb_rf_write_arbiter;
  import rf_pkg::*;

  logic                  clk;
  logic                  rst;
  logic                  busy_set;
  logic [REG_ADDR_W-1:0] busy_set_rd;
  logic                  rf_reg_write;
  logic [REG_ADDR_W-1:0] rf_write_reg;
  logic [XLEN-1:0]       rf_write_data;
  logic [NREG-1:0]       busy;
  logic [1:0]            dbg_starve_cnt;

  int n_checks;
  int n_fail;

  rf_write_arbiter_if wb ();

  rf_write_arbiter #(
    .XLEN       (32),
    .NREG       (32),
    .STARVE_MAX (3)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .wb               (wb.slave),
    .busy_set         (busy_set),
    .busy_set_rd      (busy_set_rd),
    .rf_reg_write     (rf_reg_write),
    .rf_write_reg     (rf_write_reg),
    .rf_write_data    (rf_write_data),
    .busy             (busy),
    .o_dbg_starve_cnt (dbg_starve_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic idle_inputs();
    wb.a_valid  = 1'b0;
    wb.a_rd     = '0;
    wb.a_data   = '0;
    wb.b_valid  = 1'b0;
    wb.b_rd     = '0;
    wb.b_data   = '0;
    busy_set    = 1'b0;
    busy_set_rd = '0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    idle_inputs();
    step();
    step();
    check("reset_we",    64'(rf_reg_write),  64'd0);
    check("reset_reg",   64'(rf_write_reg),  64'd0);
    check("reset_data",  64'(rf_write_data), 64'd0);
    check("reset_busy",  64'(busy),          64'd0);
    rst = 1'b0;
    step();

    // A only
    wb.a_valid = 1'b1; wb.a_rd = 5'd5; wb.a_data = 32'hDEADBEEF;
    #1;
    check("a_only_a_ready", 64'(wb.a_ready), 64'd1);
    check("a_only_b_ready", 64'(wb.b_ready), 64'd0);
    step();
    wb.a_valid = 1'b0;
    check("a_only_we",   64'(rf_reg_write),  64'd1);
    check("a_only_reg",  64'(rf_write_reg),  64'd5);
    check("a_only_data", 64'(rf_write_data), 64'hDEADBEEF);
    step();
    check("a_only_idle_we", 64'(rf_reg_write), 64'd0);

    // Starvation: A always valid, B refused three cycles then forced
    wb.a_valid = 1'b1; wb.a_rd = 5'd1;  wb.a_data = 32'h0000_0011;
    wb.b_valid = 1'b1; wb.b_rd = 5'd7;  wb.b_data = 32'h0000_0077;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("starve_b_ready_c%0d", i), 64'(wb.b_ready), 64'd0);
      check($sformatf("starve_a_ready_c%0d", i), 64'(wb.a_ready), 64'd1);
      check($sformatf("starve_cnt_c%0d", i), 64'(dbg_starve_cnt), 64'(i));
      step();
      if (i > 0) begin
        check($sformatf("starve_a_write_c%0d", i), 64'(rf_write_reg), 64'd1);
      end
    end
    #1;
    check("starve_forced_b_ready", 64'(wb.b_ready), 64'd1);
    check("starve_forced_a_ready", 64'(wb.a_ready), 64'd0);
    step();
    wb.a_valid = 1'b0;
    wb.b_valid = 1'b0;
    check("starve_b_we",   64'(rf_reg_write),   64'd1);
    check("starve_b_reg",  64'(rf_write_reg),   64'd7);
    check("starve_b_data", 64'(rf_write_data),  64'h77);
    check("starve_cnt_clr", 64'(dbg_starve_cnt), 64'd0);
    step();

    // x0 write is accepted but never reaches the register file
    wb.a_valid = 1'b1; wb.a_rd = 5'd0; wb.a_data = 32'h1;
    #1;
    check("x0_a_ready", 64'(wb.a_ready), 64'd1);
    step();
    wb.a_valid = 1'b0;
    check("x0_we",   64'(rf_reg_write), 64'd0);
    check("x0_busy", 64'(busy),         64'd0);
    busy_set = 1'b1; busy_set_rd = 5'd0;
    step();
    busy_set = 1'b0;
    check("x0_busy_set_ignored", 64'(busy), 64'd0);

    // Scoreboard set then clear by a B writeback
    busy_set = 1'b1; busy_set_rd = 5'd9;
    step();
    busy_set = 1'b0;
    check("sb_set9", 64'(busy), 64'h200);
    wb.b_valid = 1'b1; wb.b_rd = 5'd9; wb.b_data = 32'h99;
    #1;
    check("sb_b_ready", 64'(wb.b_ready), 64'd1);
    step();
    wb.b_valid = 1'b0;
    check("sb_b_we",       64'(rf_reg_write), 64'd1);
    check("sb_b_reg",      64'(rf_write_reg), 64'd9);
    check("sb_busy_during", 64'(busy),        64'h200);
    step();
    check("sb_cleared", 64'(busy), 64'd0);

    // Set coincident with the clearing edge: set wins
    busy_set = 1'b1; busy_set_rd = 5'd9;
    step();
    busy_set = 1'b0;
    wb.b_valid = 1'b1; wb.b_rd = 5'd9; wb.b_data = 32'h9A;
    step();
    wb.b_valid = 1'b0;
    check("sb2_b_we", 64'(rf_reg_write), 64'd1);
    busy_set = 1'b1; busy_set_rd = 5'd9;
    step();
    busy_set = 1'b0;
    check("sb2_set_wins", 64'(busy), 64'h200);

    // Back-to-back: A to 3, then B to 4 with no idle cycle
    wb.a_valid = 1'b1; wb.a_rd = 5'd3; wb.a_data = 32'h33;
    wb.b_valid = 1'b1; wb.b_rd = 5'd4; wb.b_data = 32'h44;
    #1;
    check("b2b_a_ready", 64'(wb.a_ready), 64'd1);
    check("b2b_b_ready0", 64'(wb.b_ready), 64'd0);
    step();
    wb.a_valid = 1'b0;
    #1;
    check("b2b_w1_we",   64'(rf_reg_write), 64'd1);
    check("b2b_w1_reg",  64'(rf_write_reg), 64'd3);
    check("b2b_b_ready1", 64'(wb.b_ready),  64'd1);
    step();
    wb.b_valid = 1'b0;
    check("b2b_w2_we",   64'(rf_reg_write),  64'd1);
    check("b2b_w2_reg",  64'(rf_write_reg),  64'd4);
    check("b2b_w2_data", 64'(rf_write_data), 64'h44);
    step();
    check("b2b_idle_we", 64'(rf_reg_write), 64'd0);

    // Reset mid-stream while B holds valid
    wb.b_valid = 1'b1; wb.b_rd = 5'd2; wb.b_data = 32'h22;
    step();
    check("mid_pre_we", 64'(rf_reg_write), 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_we",      64'(rf_reg_write),   64'd0);
    check("mid_rst_reg",     64'(rf_write_reg),   64'd0);
    check("mid_rst_data",    64'(rf_write_data),  64'd0);
    check("mid_rst_busy",    64'(busy),           64'd0);
    check("mid_rst_b_ready", 64'(wb.b_ready),     64'd0);
    check("mid_rst_cnt",     64'(dbg_starve_cnt), 64'd0);
    step();
    check("mid_rst_held_we", 64'(rf_reg_write), 64'd0);
    rst = 1'b0;
    #1;
    check("post_rst_b_ready", 64'(wb.b_ready), 64'd1);
    step();
    wb.b_valid = 1'b0;
    check("post_rst_we",   64'(rf_reg_write),  64'd1);
    check("post_rst_reg",  64'(rf_write_reg),  64'd2);
    check("post_rst_data", 64'(rf_write_data), 64'h22);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
